// File: rtl/imem_uart_loader.sv
// UART byte-stream loader for the instruction RAM.
// Frames a counted, checksummed image into word writes and holds the CPU meanwhile.
module imem_uart_loader #(
   parameter int unsigned MAX_WORDS      = 256,
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t        state, nxt;
   logic [7:0]    cnt_hi;
   logic [15:0]   cnt;
   logic [15:0]   word_idx;
   logic [15:0]   n_rx;
   logic [1:0]    byte_idx;
   logic [23:0]   shreg;
   logic [7:0]    csum;
   logic [TW-1:0] tcnt;
   logic          active;
   logic          tmo;
   logic          acc;
   logic          last_byte;

   assign active    = state inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM};
   assign acc       = rx_valid && active && !start;
   assign tmo       = tcnt == TW'(TIMEOUT_CYCLES - 1);
   assign n_rx      = {cnt_hi, rx_data};
   assign last_byte = byte_idx == 2'd3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (start) begin
         nxt = S_CNT_HI;
      end else if (active && !rx_valid && tmo) begin
         nxt = S_ERR;
      end else if (rx_valid) begin
         case (state)
            S_CNT_HI: nxt = S_CNT_LO;
            S_CNT_LO: begin
               if (n_rx > 16'(MAX_WORDS)) nxt = S_ERR;
               else if (n_rx == 16'd0)    nxt = S_CSUM;
               else                       nxt = S_DATA;
            end
            S_DATA: begin
               if (last_byte && word_idx == cnt - 16'd1) nxt = S_CSUM;
            end
            S_CSUM:  nxt = (csum == rx_data) ? S_DONE : S_ERR;
            default: nxt = state;
         endcase
      end
   end

   // A failed load keeps the CPU held so a corrupt image never runs.
   always_comb begin
      cpu_hold = active || (state == S_ERR);
      busy     = active;
      done     = state == S_DONE;
      error    = state == S_ERR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_hi     <= '0;
         cnt        <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         shreg      <= '0;
         csum       <= '0;
         tcnt       <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else if (start) begin
         cnt        <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         csum       <= '0;
         tcnt       <= '0;
         imem_we    <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (!active || rx_valid) tcnt <= '0;
         else if (!tmo)           tcnt <= tcnt + TW'(1);
         if (acc) begin
            if (state != S_CSUM) csum <= csum + rx_data;
            case (state)
               S_CNT_HI: cnt_hi <= rx_data;
               S_CNT_LO: cnt    <= n_rx;
               S_DATA: begin
                  shreg    <= {shreg[15:0], rx_data};
                  byte_idx <= byte_idx + 2'd1;
                  if (last_byte) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= ADDR_BASE + 32'({word_idx, 2'b00});
                     imem_wdata <= {shreg, rx_data};
                     word_idx   <= word_idx + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction memory. Takes a byte stream from the UART receiver, frames it into a program image, and issues 32-bit word writes into the instruction RAM.
- Holds the pipeline CPU while a load is in progress.
- Checks the image length and a checksum. Releases the CPU only when a complete and valid image has been written.

Parameters:
- MAX_WORDS, 256: capacity of the instruction memory, indexed by Address[9:2].
- ADDR_BASE, 32'h00000000: byte address of word 0.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins or restarts a load
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- imem_we  out  1  word write enable, one-cycle pulse
- imem_addr  out  32  byte address of the write, word-aligned
- imem_wdata  out  32  instruction word to write
- cpu_hold  out  1  when high, keeps the CPU in reset
- busy  out  1  a frame is in progress
- done  out  1  last load succeeded; sticky
- error  out  1  last load failed; sticky

Behaviour:
- Reset: all outputs are 0. State is IDLE. All counters and the checksum are cleared.
- Frame format, in byte order:
  - CNT_HI, CNT_LO: word count N, 16 bits, big-endian.
  - N x 4 data bytes: each word is sent MSB first.
  - One CSUM byte: the mod-256 sum of every byte from CNT_HI through the last data byte must equal CSUM.
- State machine: IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
- start (any state):
  - Go to CNT_HI.
  - Clear the checksum, byte index, word index, done and error.
  - Set cpu_hold=1 and busy=1 from the next cycle.
- start takes priority over rx_valid in the same cycle. That byte is discarded.
- rx_valid is ignored in IDLE, DONE and ERR.
- CNT_HI to CNT_LO to next state:
  - If N > MAX_WORDS, go to ERR.
  - If N == 0, go to CSUM.
  - Otherwise go to DATA.
- DATA:
  - Shift each byte into a 32-bit assembly register, MSB first.
  - A 2-bit byte index wraps 3 to 0.
  - On the 4th byte (cycle t), in cycle t+1:
    - imem_we=1 for exactly one cycle
    - imem_addr = ADDR_BASE + 4*word_idx
    - imem_wdata = the assembled word
  - word_idx then increments.
  - After word N-1 is written, go to CSUM.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- CSUM:
  - If the checksum matches, go to DONE: done=1, busy=0, cpu_hold=0.
  - Otherwise go to ERR.
- ERR:
  - error=1, busy=0, cpu_hold stays 1, so a partial or corrupt image never runs.
  - Only start or reset leaves ERR.
- Timeout:
  - In CNT_HI, CNT_LO, DATA and CSUM, a counter is cleared on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, go to ERR.
- Abort: start in the middle of a frame restarts cleanly.
  - A write pulse already scheduled for the next cycle is suppressed.
  - Words already written stay in the RAM.
- reset_n low in the middle of a frame:
  - Return immediately to IDLE with all outputs 0.
  - cpu_hold drops, so the CPU runs whatever is in the RAM.
- Widths and arithmetic:
  - word_idx is 16 bits. The checksum is 8 bits and wraps.
  - imem_addr is ADDR_BASE plus {word_idx,2'b00}, zero-extended to 32 bits.
- Back-to-back rx_valid (every cycle) must be accepted without loss. The write pulse never stalls the input.

Test Plan:
- Nominal 2-word load.
  - Stimulus: start, then bytes 00 02 00 00 28 21 20 A4 00 04 13.
  - Required: imem_we pulses once with (0x0, 0x00002821) and once with (0x4, 0x20A40004), each one cycle after the 4th byte of its word. Then done=1, cpu_hold=0, error=0.
- Bad checksum.
  - Stimulus: the same frame with last byte 14.
  - Required: both writes occur; then error=1, cpu_hold=1, done=0.
- Oversize and empty counts.
  - Stimulus: N=0x0101 (257).
  - Required: ERR right after CNT_LO; no imem_we.
  - Stimulus: N=0 with CSUM 00.
  - Required: done=1; no writes.
- Timeout.
  - Stimulus: with TIMEOUT_CYCLES=16, send 00 01 00 and then go silent.
  - Required: error=1 sixteen cycles after the last byte; cpu_hold stays 1.
- Restart and collision.
  - Stimulus: start in the middle of DATA, asserted together with rx_valid.
  - Required: that byte is dropped and no pending write fires. A following valid 1-word frame writes address 0x0 and gives done=1.
- Asynchronous reset.
  - Stimulus: reset_n=0 during DATA, then a back-to-back rx_valid stream on a 3-word frame after reset is released.
  - Required: all outputs are 0 during reset; the stream after release gives three writes at 0x0, 0x4, 0x8 with no bytes lost.
